// File: rtl/yakbd_ps2_rx_if.sv
// Key-event bus between the PS/2 receiver and the ASCII translation stage.
interface yakbd_ps2_rx_if;
  logic [7:0] pscode;
  logic       key_valid;
  logic       key_ready;
  logic       shift;
  logic       ctrl;
  logic       frame_err;
  logic       overflow;

  modport master (
    output pscode, key_valid, shift, ctrl, frame_err, overflow,
    input  key_ready
  );

  modport slave (
    input  pscode, key_valid, shift, ctrl, frame_err, overflow,
    output key_ready
  );
endinterface

// File: rtl/yakbd_ps2_rx.sv
// PS/2 keyboard receiver: line sync/filter, 11-bit frame deserialiser,
// E0/F0 prefix stripping, Shift/Ctrl tracking and a one-entry event register.
module yakbd_ps2_rx #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  yakbd_ps2_rx_if.master kbd
);

  localparam int unsigned FC_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic            c_s1, c_s2, d_s1, d_s2;
  logic            fclk, fclk_q;
  logic [FC_W-1:0] fcnt;
  logic            strike;

  logic [1:0]      state, state_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            par, par_d;
  logic [WD_W-1:0] wd, wd_d;
  logic            byte_ok_c, err_c, tmo_c;

  logic ext, ext_d, brk, brk_d;
  logic shl, shl_d, shr, shr_d, ctl_l, ctl_l_d, ctl_r, ctl_r_d;
  logic ev_c;

  // Two-flop synchronisers; idle lines are high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2_clk;
      c_s2 <= c_s1;
      d_s1 <= ps2_data;
      d_s2 <= d_s1;
    end
  end

  // Glitch filter: fclk follows c_s2 only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk   <= 1'b1;
      fclk_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      fclk_q <= fclk;
      if (c_s2 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FC_W'(FILTER_LEN - 1)) begin
        fclk <= c_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FC_W'(1);
      end
    end
  end

  assign strike = fclk_q & ~fclk;

  // Frame state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      wd      <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      par     <= par_d;
      wd      <= wd_d;
    end
  end

  // Frame next-state: deserialise, check parity/stop, watchdog
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_d     = par;
    wd_d      = '0;
    byte_ok_c = 1'b0;
    err_c     = 1'b0;
    tmo_c     = 1'b0;
    if (state != ST_IDLE) wd_d = wd + WD_W'(1);
    case (state)
      ST_IDLE: begin
        if (strike && !d_s2) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (strike) begin
          shreg_d   = {d_s2, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strike) begin
          par_d   = d_s2;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strike) begin
          state_d = ST_IDLE;
          if (d_s2 && ((^shreg) ^ par)) byte_ok_c = 1'b1;
          else                          err_c     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (strike) begin
      wd_d = '0;
    end else if ((state != ST_IDLE) && (wd_d == WD_W'(TIMEOUT))) begin
      state_d = ST_IDLE;
      wd_d    = '0;
      err_c   = 1'b1;
      tmo_c   = 1'b1;
    end
  end

  // Decoder: prefix flags, modifier updates and event generation
  always_comb begin
    ext_d   = ext;
    brk_d   = brk;
    shl_d   = shl;
    shr_d   = shr;
    ctl_l_d = ctl_l;
    ctl_r_d = ctl_r;
    ev_c    = 1'b0;
    if (tmo_c) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok_c) begin
      case (shreg)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (shreg == 8'h12)      shl_d = ~brk;
          else if (shreg == 8'h59) shr_d = ~brk;
          else if (shreg == 8'h14) begin
            if (ext) ctl_r_d = ~brk;
            else     ctl_l_d = ~brk;
          end else begin
            ev_c = ~brk;
          end
        end
      endcase
    end
  end

  // Decoder state and modifier outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      shl      <= 1'b0;
      shr      <= 1'b0;
      ctl_l    <= 1'b0;
      ctl_r    <= 1'b0;
      kbd.shift <= 1'b0;
      kbd.ctrl  <= 1'b0;
    end else begin
      ext      <= ext_d;
      brk      <= brk_d;
      shl      <= shl_d;
      shr      <= shr_d;
      ctl_l    <= ctl_l_d;
      ctl_r    <= ctl_r_d;
      kbd.shift <= shl_d | shr_d;
      kbd.ctrl  <= ctl_l_d | ctl_r_d;
    end
  end

  // One-entry event register with overflow on a blocked load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd.pscode    <= 8'h00;
      kbd.key_valid <= 1'b0;
      kbd.frame_err <= 1'b0;
      kbd.overflow  <= 1'b0;
    end else begin
      kbd.frame_err <= err_c;
      kbd.overflow  <= 1'b0;
      if (ev_c) begin
        if (!kbd.key_valid || kbd.key_ready) begin
          kbd.pscode    <= shreg;
          kbd.key_valid <= 1'b1;
        end else begin
          kbd.overflow <= 1'b1;
        end
      end else if (kbd.key_valid && kbd.key_ready) begin
        kbd.key_valid <= 1'b0;
      end
    end
  end

endmodule
